// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: 160-byte OAM DMA engine with OAM write-port arbitration and CPU read gating.
module oam_dma_ctrl #(
  parameter int BYTE_CYCLES = 4,
  parameter int START_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write,
  input  logic [7:0]  d_wr,
  output logic [7:0]  reg_d_rd,
  output logic        src_rd,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_d_in,
  input  logic [7:0]  cpu_oam_addr,
  input  logic        cpu_oam_write,
  input  logic [7:0]  cpu_oam_d_in,
  output logic [7:0]  cpu_oam_d_rd,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_d,
  output logic        oam_write,
  input  logic        lcd_ena,
  input  logic [1:0]  ppu_phase,
  output logic        dma_active,
  output logic        bus_busy
);
  localparam int SW = $clog2(BYTE_CYCLES);
  localparam int DW = $clog2(START_DELAY + 1);
  typedef enum logic [1:0] {IDLE, START, XFER} state_t;
  state_t         state;
  logic [7:0]     page, idx, data_buf;
  logic [SW-1:0]  slot;
  logic [DW-1:0]  delay;
  logic           dma_wr, ppu_owns;
  always_ff @(posedge clk)
    if (!rst) begin
      state    <= IDLE;
      page     <= 8'h00;
      idx      <= 8'd0;
      slot     <= '0;
      delay    <= '0;
      data_buf <= 8'h00;
    end else if (reg_write) begin
      page  <= d_wr;
      idx   <= 8'd0;
      slot  <= '0;
      delay <= '0;
      state <= START;
    end else if (state == START) begin
      delay <= delay + DW'(1);
      if (delay == DW'(START_DELAY - 1)) begin
        state <= XFER;
        slot  <= '0;
      end
    end else if (state == XFER) begin
      if (slot == SW'(1)) data_buf <= src_d_in;
      if (slot == SW'(BYTE_CYCLES - 1)) begin
        slot  <= '0;
        idx   <= (idx == 8'd159) ? 8'd0 : idx + 8'd1;
        state <= (idx == 8'd159) ? IDLE : XFER;
      end else slot <= slot + SW'(1);
    end
  assign dma_active   = state != IDLE;
  assign bus_busy     = dma_active;
  assign reg_d_rd     = page;
  assign ppu_owns     = lcd_ena & ppu_phase[1];
  assign dma_wr       = (state == XFER) & (slot == SW'(BYTE_CYCLES - 1));
  assign src_rd       = rst & (state == XFER) & (slot == '0);
  assign src_addr     = {(page >= 8'hE0) ? page - 8'h20 : page, idx};
  // With two clocks per byte the write slot is also the capture slot, so forward the read data.
  assign oam_write    = rst & (dma_active ? dma_wr : cpu_oam_write & ~ppu_owns);
  assign oam_addr     = dma_active ? idx : cpu_oam_addr;
  assign oam_d        = dma_active ? ((slot == SW'(1)) ? src_d_in : data_buf) : d_wr;
  assign cpu_oam_d_rd = (dma_active | ppu_owns) ? 8'hFF : cpu_oam_d_in;
endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

OAM DMA controller and OAM write-port arbiter. A CPU write to the DMA register starts a copy of 160 bytes from a 256-byte source page into OAM. While the copy runs, and while the PPU is in OAM scan or draw, the block gates CPU access to OAM. It sits between the CPU bus decode, the system memory read port and the OAM write port in front of the PPU.

## Interface
- `BYTE_CYCLES`, default 4: clocks per transferred byte; must be ≥ 2.
- `START_DELAY`, default 4: idle clocks between the register write and the first byte slot; must be ≥ 1.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `reg_write` in 1: CPU write strobe to the DMA register (0xFF46).
- `d_wr` in 8: CPU write data.
- `reg_d_rd` out 8: DMA register readback, i.e. the last written page.
- `src_rd` out 1: source read strobe.
- `src_addr` out 16: source byte address.
- `src_d_in` in 8: source read data, valid exactly 1 clock after `src_rd`.
- `cpu_oam_addr` in 8: CPU OAM byte address.
- `cpu_oam_write` in 1: CPU OAM write strobe.
- `cpu_oam_d_in` in 8: OAM read data for the CPU address.
- `cpu_oam_d_rd` out 8: gated OAM read data returned to the CPU.
- `oam_addr` out 8: OAM write-port address.
- `oam_d` out 8: OAM write-port data.
- `oam_write` out 1: OAM write-port strobe.
- `lcd_ena` in 1: LCDC.7.
- `ppu_phase` in 2: 0 HBLANK, 1 VBLANK, 2 OAM_SCAN, 3 DRAW.
- `dma_active` out 1: high from the cycle after the register write until the last OAM write completes.
- `bus_busy` out 1: equals `dma_active`; the CPU bus decode stalls non-HRAM accesses while it is high.

## Operation
- **States:** IDLE, START, XFER.
- **Registers:**
  - `page` (8 b)
  - `idx` (8 b, 0..159)
  - `slot` (clog2(`BYTE_CYCLES`) b)
  - `delay` counter
  - `data_buf` (8 b)
- **IDLE:** `reg_write` causes `page <= d_wr`, `idx <= 0`, `delay <= 0`, and a move to START.
- **START:** counts `START_DELAY` clocks, then moves to XFER with `slot = 0`.
- **XFER slot** for byte `idx`:
  - `slot == 0`: `src_rd = 1`, `src_addr = {page', idx}`.
  - `slot == 1`: `data_buf <= src_d_in`.
  - `slot == BYTE_CYCLES-1`: `oam_write = 1`, `oam_addr = idx`, `oam_d = data_buf`. Then `idx` increments. After `idx == 159` the state goes to IDLE.
- **Page remap:** `page' = page >= 0xE0 ? page - 0x20 : page` (echo RAM). `src_addr` is 16 b with no carry out. `idx` never exceeds 159.
- **Restart:** `reg_write` in START or XFER reloads `page`, clears `idx`, `slot` and `delay`, and re-enters START. A partially completed slot is abandoned with no OAM write.
- **OAM write-port arbitration** (combinational):
  - `dma_active`: the DMA owns the port, and CPU writes are dropped.
  - Otherwise: CPU writes pass through (`oam_addr = cpu_oam_addr`, `oam_d = d_wr`) if `~lcd_ena` or `ppu_phase ∈ {HBLANK, VBLANK}`. Otherwise they are dropped.
- **CPU reads:** `cpu_oam_d_rd = 0xFF` if `dma_active`, or if `lcd_ena` and `ppu_phase ∈ {OAM_SCAN, DRAW}`. Otherwise `cpu_oam_d_rd = cpu_oam_d_in`.
- **`reg_d_rd`:** returns `page`; readable at any time.

## Timing
- **Reset values:**
  - state IDLE
  - `page = 0x00`
  - `idx = slot = delay = 0`
  - `dma_active = bus_busy = 0`
  - `src_rd = 0`, `oam_write = 0` (arbiter inactive)
- **Reset mid-transfer** aborts immediately: no further OAM writes, and OAM contents already written remain.
- **Start latency:** `reg_write` sampled at edge N gives `dma_active = 1` from N+1.
  - First `src_rd` at cycle N+1+`START_DELAY`.
  - First `oam_write` at N+`START_DELAY`+`BYTE_CYCLES`.
- **Total:** `dma_active` is high for exactly `START_DELAY` + 160·`BYTE_CYCLES` cycles and falls the cycle after the write of OAM byte 159.
- **Write cadence:** exactly one `oam_write` per `BYTE_CYCLES` clocks, at strictly increasing addresses 0..159.
- **Simultaneous events:**
  - CPU `cpu_oam_write` in the same cycle as a DMA write: the DMA wins and the CPU write is lost.
  - `reg_write` in the same cycle as the byte-159 write: that byte's write occurs and the restart takes effect.
- **Phase changes:** `ppu_phase` changes affect the gating in the same cycle. There is no registering in the arbiter.

## Test plan
- **Full copy:** page 0xC1 filled with pattern i^0x5A, defaults, write 0xC1 → 160 `oam_write` pulses, `oam_addr` 0..159, data i^0x5A, `dma_active` high for 644 cycles, `reg_d_rd` = 0xC1.
- **Echo remap:** write 0xE3 → every `src_addr[15:8]` = 0xC3.
- **Restart:** write 0xC0, then at byte 50 write 0xD0 → OAM 0..49 holds C0 data, OAM 0..159 is then overwritten with D0 data, no write to `oam_addr` 50 of C0 data, total active length restarts.
- **CPU gating:**
  - During DMA, a CPU read returns 0xFF and a CPU write of 0x33 to addr 200 is dropped.
  - With `lcd_ena` = 1, phase DRAW: CPU read returns 0xFF.
  - Phase HBLANK: a CPU write of 0x33 lands on OAM addr 200.
- **LCD off:** `lcd_ena` = 0, phase DRAW, no DMA → CPU read/write pass through unchanged.
- **Reset abort:** assert `rst` = 0 at byte 80 → next cycle `dma_active` = 0, `oam_write` = 0, `reg_d_rd` = 0x00, no further writes.
